dds_ramp_sequencer: RTL and testbench
=====================================

# dds_ramp_sequencer

Upstream command sequencer for the MagiQ AD9910 pulser-card serializer. It accepts one high-level amplitude/frequency ramp request and issues the fixed series of serializer commands over the `dds_cmd`/`dds_data`/`dds_ready` handshake, one command at a time. It waits for `ndone` completion between commands. It also supports a direction-only request that toggles an already-running ramp.

## Interface
Parameters:
- `STROBE_CYCLES`, 4: clocks `dds_ready` is held high per command (min 2).
- `TIMEOUT_CYCLES`, 4096: max clocks to wait for serializer completion after strobe release.

Ports:
- `clk`  in  1  system clock; every register is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-clock request pulse for the full ramp sequence.
- `dir_only`  in  1  one-clock request pulse for RAMPDIRECTION only.
- `lower_limit`, `upper_limit`  in  32 each  ramp limits.
- `step_up`, `step_down`  in  32 each  increment and decrement step sizes.
- `rate_up`, `rate_down`  in  16 each  positive-slope and negative-slope step rates.
- `cfr2_bits`  in  5  {DR destination[1:0], DR enable, no-dwell high, no-dwell low}.
- `direction`  in  1  ramp direction bit.
- `ndone`  in  1  serializer busy flag (async to `clk`; synchronised internally).
- `dds_cmd`  out  4  serializer command code.
- `dds_data`  out  64  serializer payload.
- `dds_ready`  out  1  write strobe to the serializer FIFO.
- `busy`  out  1  sequence in progress.
- `seq_done`  out  1  one-clock pulse when a sequence ends, normally or by abort.
- `error`  out  1  sticky timeout flag; cleared by the next accepted request.

## Operation
- Reset values: all outputs 0, FSM in IDLE, latched request cleared.
- Request acceptance:
  - Requests are accepted only in IDLE. `start` and `dir_only` pulses outside IDLE are ignored.
  - When accepted, all request inputs are latched in the same cycle and `busy` goes to 1.
  - If `start` and `dir_only` arrive together, `start` wins; the full sequence already ends with RAMPDIRECTION.
- Full sequence, in order (cmd code: payload):
  1. 5 RAMPLIMITS: {upper_limit, lower_limit}
  2. 3 RAMPSTEP: {step_down, step_up}
  3. 4 RAMPTIMESTEP: {32'h0, rate_down, rate_up}
  4. 6 CFR2RAMP: {59'h0, cfr2_bits}
  5. A RAMPDIRECTION: {63'h0, direction}
- Direction-only sequence: step 5 only.
- FSM states: IDLE → LOAD → STROBE → RELEASE → WAIT_DONE → (NEXT → LOAD | FINISH) → IDLE.
  - LOAD: drive `dds_cmd`/`dds_data` for the current step. Clear the `seen_busy` flag.
  - STROBE: hold `dds_ready`=1 for `STROBE_CYCLES` clocks.
  - RELEASE: set `dds_ready`=0. Start the timeout counter.
  - WAIT_DONE: exit when the synchronised `ndone` is 0 and `seen_busy`=1. `seen_busy` is set by any synchronised `ndone`=1 from STROBE onward.
  - NEXT: advance the step index.
  - FINISH: pulse `seq_done`. Clear `busy`.
- `dds_cmd`/`dds_data` are stable from LOAD through WAIT_DONE of each step and change only in LOAD.
- `ndone` passes through a 2-flop synchroniser before use.

## Timing
- First `dds_ready` rise: 2 clocks after the accepted request (IDLE→LOAD→STROBE).
- Per-command overhead: 1 (LOAD) + `STROBE_CYCLES` + 1 (RELEASE) + synchroniser latency (2) + serializer time.
- `dds_ready` low time between commands is at least 4 clocks, which guarantees the serializer write FSM re-arms.
- Timeout:
  - If WAIT_DONE lasts `TIMEOUT_CYCLES` clocks after RELEASE, the FSM sets `error`=1, drops any remaining steps and goes to FINISH.
  - `seq_done` still pulses on a timeout abort.
- Counter widths: timeout counter is $clog2(`TIMEOUT_CYCLES`+1); strobe counter is $clog2(`STROBE_CYCLES`+1). Neither counter wraps; each saturates at its terminal count.
- Reset mid-operation: `dds_ready` drops immediately (asynchronous); nothing else is flushed. A partially programmed ramp is left on the card, and software must re-issue the request.
- Serializer already idle (`ndone`=0 throughout): `seen_busy` never sets, so the step ends on timeout with `error`=1. This is the intended failure detection.

## Structure
- Shared package `dds_pkg`:
  - Serializer command-code localparams (INITSETCFR2…RAMPDIRECTION, 4'h0–4'hA), which the serializer also uses.
  - FSM state enum.
  - Payload-packing functions for each command.
- Sub-module `sync2` (2-flop synchroniser, async active-low reset), instantiated for `ndone`.

## Test plan
- `start` with lower=32'h0000_1000, upper=32'h0000_F000, step_up=1, step_down=2, rate_up=16'h0010, rate_down=16'h0020, cfr2=5'b10110, dir=1, and a serializer model that asserts ndone 3 clocks after strobe for 20 clocks -> exactly 5 strobes with cmd 5,3,4,6,A. Payloads 64'h0000F000_00001000, 64'h2_00000001, 64'h00200010, 64'h16, 64'h1. One `seq_done` pulse; `error`=0.
- `dir_only` with dir=0 -> single strobe, cmd A, data 64'h0; `seq_done` pulses; `busy` high for the duration.
- `start` while busy, and `start`+`dir_only` together in IDLE -> the busy request is ignored; the simultaneous pair runs the full 5-step sequence.
- Serializer model never raises ndone, `TIMEOUT_CYCLES`=64 -> after the first strobe, `error`=1 about 66 clocks after release. No further strobes; `seq_done` pulses; the next `start` clears `error`.
- `rst_n` low during the STROBE of step 3 -> `dds_ready`=0 asynchronously. All outputs are 0; after release, the FSM is in IDLE and accepts a new `start`.
- Check `dds_ready` width = `STROBE_CYCLES` and gap ≥4 clocks between every pair of strobes, and `dds_data` stable for every cycle `dds_ready`=1.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the AD9910 serializer command path: command codes,
// sequencer state encoding and payload packing for each ramp command.
package dds_pkg;

    localparam logic [3:0] INITSETCFR2   = 4'h0;
    localparam logic [3:0] RAMPSTEP      = 4'h3;
    localparam logic [3:0] RAMPTIMESTEP  = 4'h4;
    localparam logic [3:0] RAMPLIMITS    = 4'h5;
    localparam logic [3:0] CFR2RAMP      = 4'h6;
    localparam logic [3:0] RAMPDIRECTION = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        RELEASE,
        WAIT_DONE,
        NEXT,
        FINISH
    } seq_state_t;

    typedef struct packed {
        logic [31:0] lower_limit;
        logic [31:0] upper_limit;
        logic [31:0] step_up;
        logic [31:0] step_down;
        logic [15:0] rate_up;
        logic [15:0] rate_down;
        logic [4:0]  cfr2_bits;
        logic        direction;
    } ramp_req_t;

    // Step index 0..4 walks the full sequence; a direction-only request starts at 4.
    localparam logic [2:0] STEP_LIMITS    = 3'd0;
    localparam logic [2:0] STEP_STEP      = 3'd1;
    localparam logic [2:0] STEP_TIMESTEP  = 3'd2;
    localparam logic [2:0] STEP_CFR2      = 3'd3;
    localparam logic [2:0] STEP_DIRECTION = 3'd4;

    function automatic logic [63:0] pack_limits(input logic [31:0] upper, input logic [31:0] lower);
        return {upper, lower};
    endfunction

    function automatic logic [63:0] pack_step(input logic [31:0] down, input logic [31:0] up);
        return {down, up};
    endfunction

    function automatic logic [63:0] pack_timestep(input logic [15:0] down, input logic [15:0] up);
        return {32'h0, down, up};
    endfunction

    function automatic logic [63:0] pack_cfr2(input logic [4:0] bits);
        return {59'h0, bits};
    endfunction

    function automatic logic [63:0] pack_direction(input logic dir);
        return {63'h0, dir};
    endfunction

    function automatic logic [3:0] step_cmd(input logic [2:0] step);
        case (step)
            STEP_LIMITS:   return RAMPLIMITS;
            STEP_STEP:     return RAMPSTEP;
            STEP_TIMESTEP: return RAMPTIMESTEP;
            STEP_CFR2:     return CFR2RAMP;
            default:       return RAMPDIRECTION;
        endcase
    endfunction

    function automatic logic [63:0] step_payload(input logic [2:0] step, input ramp_req_t req);
        case (step)
            STEP_LIMITS:   return pack_limits(req.upper_limit, req.lower_limit);
            STEP_STEP:     return pack_step(req.step_down, req.step_up);
            STEP_TIMESTEP: return pack_timestep(req.rate_down, req.rate_up);
            STEP_CFR2:     return pack_cfr2(req.cfr2_bits);
            default:       return pack_direction(req.direction);
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/dds_ramp_sequencer.sv
// Issues the AD9910 ramp programming commands to the serializer one at a time,
// waiting for ndone completion between commands, with a per-command timeout.
module dds_ramp_sequencer
    import dds_pkg::*;
#(
    parameter int STROBE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dir_only,
    input  logic [31:0] lower_limit,
    input  logic [31:0] upper_limit,
    input  logic [31:0] step_up,
    input  logic [31:0] step_down,
    input  logic [15:0] rate_up,
    input  logic [15:0] rate_down,
    input  logic [4:0]  cfr2_bits,
    input  logic        direction,
    input  logic        ndone,
    output logic [3:0]  dds_cmd,
    output logic [63:0] dds_data,
    output logic        dds_ready,
    output logic        busy,
    output logic        seq_done,
    output logic        error
);

    localparam int SW = $clog2(STROBE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STROBE_LAST  = SW'(STROBE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t    state_reg, state_next;
    logic [2:0]    step_reg, step_next;
    ramp_req_t     req_reg, req_next;
    logic [SW-1:0] strobe_cnt_reg, strobe_cnt_next;
    logic [TW-1:0] timeout_cnt_reg, timeout_cnt_next;
    logic          seen_busy_reg, seen_busy_next;
    logic [3:0]    cmd_reg, cmd_next;
    logic [63:0]   data_reg, data_next;
    logic          ready_reg, ready_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          error_reg, error_next;
    logic          ndone_sync;

    sync2 u_ndone_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ndone),
        .q     (ndone_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            step_reg        <= STEP_LIMITS;
            req_reg         <= '0;
            strobe_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
            seen_busy_reg   <= 1'b0;
            cmd_reg         <= '0;
            data_reg        <= '0;
            ready_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            step_reg        <= step_next;
            req_reg         <= req_next;
            strobe_cnt_reg  <= strobe_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
            seen_busy_reg   <= seen_busy_next;
            cmd_reg         <= cmd_next;
            data_reg        <= data_next;
            ready_reg       <= ready_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        step_next        = step_reg;
        req_next         = req_reg;
        strobe_cnt_next  = strobe_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;
        seen_busy_next   = seen_busy_reg;
        cmd_next         = cmd_reg;
        data_next        = data_reg;
        error_next       = error_reg;

        case (state_reg)
            IDLE: begin
                if (start || dir_only) begin
                    state_next = LOAD;
                    step_next  = start ? STEP_LIMITS : STEP_DIRECTION;
                    req_next   = '{lower_limit: lower_limit, upper_limit: upper_limit,
                                   step_up: step_up, step_down: step_down,
                                   rate_up: rate_up, rate_down: rate_down,
                                   cfr2_bits: cfr2_bits, direction: direction};
                    error_next = 1'b0;
                end
            end
            LOAD: begin
                seen_busy_next  = 1'b0;
                strobe_cnt_next = SW'(1);
                state_next      = STROBE;
            end
            STROBE: begin
                if (ndone_sync) seen_busy_next = 1'b1;
                if (strobe_cnt_reg == STROBE_LAST) begin
                    state_next = RELEASE;
                end else begin
                    strobe_cnt_next = strobe_cnt_reg + SW'(1);
                end
            end
            RELEASE: begin
                if (ndone_sync) seen_busy_next = 1'b1;
                timeout_cnt_next = '0;
                state_next       = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ndone_sync) seen_busy_next = 1'b1;
                // Completion requires having seen the serializer go busy first.
                if (!ndone_sync && seen_busy_reg) begin
                    state_next = (step_reg == STEP_DIRECTION) ? FINISH : NEXT;
                end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    error_next = 1'b1;
                    state_next = FINISH;
                end else begin
                    timeout_cnt_next = timeout_cnt_reg + TW'(1);
                end
            end
            NEXT: begin
                step_next  = step_reg + 3'd1;
                state_next = LOAD;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Command and payload are captured on entry to LOAD and held until the next LOAD.
        if (state_next == LOAD) begin
            cmd_next  = step_cmd(step_next);
            data_next = step_payload(step_next, req_next);
        end

        ready_next = (state_next == STROBE);
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == FINISH);
    end

    assign dds_cmd   = cmd_reg;
    assign dds_data  = data_reg;
    assign dds_ready = ready_reg;
    assign busy      = busy_reg;
    assign seq_done  = done_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_dds_ramp_sequencer.sv
// Directed bench for dds_ramp_sequencer with a serializer model and a
// request-level expectation queue checked by a per-cycle monitor.
module tb_dds_ramp_sequencer;

    localparam int STROBE  = 4;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [3:0]  cmd;
        logic [63:0] data;
    } strobe_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, dir_only;
    logic [31:0] lower_limit, upper_limit, step_up, step_down;
    logic [15:0] rate_up, rate_down;
    logic [4:0]  cfr2_bits;
    logic        direction;
    logic        ndone;
    logic [3:0]  dds_cmd;
    logic [63:0] dds_data;
    logic        dds_ready, busy, seq_done, error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int done_cnt = 0;
    int exp_done = 0;
    bit ser_respond = 1'b1;

    strobe_t     exp_q[$];
    bit          exp_err_q[$];
    logic [3:0]  log_cmd[$];
    logic [63:0] log_data[$];

    dds_ramp_sequencer #(
        .STROBE_CYCLES  (STROBE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dir_only    (dir_only),
        .lower_limit (lower_limit),
        .upper_limit (upper_limit),
        .step_up     (step_up),
        .step_down   (step_down),
        .rate_up     (rate_up),
        .rate_down   (rate_down),
        .cfr2_bits   (cfr2_bits),
        .direction   (direction),
        .ndone       (ndone),
        .dds_cmd     (dds_cmd),
        .dds_data    (dds_data),
        .dds_ready   (dds_ready),
        .busy        (busy),
        .seq_done    (seq_done),
        .error       (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serializer: goes busy 3 clocks after each strobe rises, for 20 clocks.
    initial begin
        ndone = 1'b0;
        forever begin
            @(posedge dds_ready);
            if (ser_respond) begin
                repeat (3) @(posedge clk);
                #1 ndone = 1'b1;
                repeat (20) @(posedge clk);
                #1 ndone = 1'b0;
            end
        end
    end

    // Request-level model: which commands a request must produce.
    task automatic expect_seq(input bit full, input bit responds);
        strobe_t e;
        int base_n = exp_q.size();
        if (full) begin
            e.cmd = 4'h5; e.data = {upper_limit, lower_limit};         exp_q.push_back(e);
            e.cmd = 4'h3; e.data = {step_down, step_up};               exp_q.push_back(e);
            e.cmd = 4'h4; e.data = {32'h0, rate_down, rate_up};        exp_q.push_back(e);
            e.cmd = 4'h6; e.data = {59'h0, cfr2_bits};                 exp_q.push_back(e);
        end
        e.cmd = 4'hA; e.data = {63'h0, direction};
        exp_q.push_back(e);
        // A silent serializer aborts the request after its first command.
        if (!responds) begin
            while (exp_q.size() > base_n + 1) void'(exp_q.pop_back());
        end
        exp_err_q.push_back(!responds);
        exp_done++;
    endtask

    task automatic pulse(input bit s, input bit d);
        @(posedge clk); #1;
        start = s; dir_only = d;
        @(posedge clk); #1;
        start = 1'b0; dir_only = 1'b0;
    endtask

    task automatic wait_seq(input int budget);
        int n = 0;
        while (done_cnt < exp_done && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("seq_complete", done_cnt == exp_done, done_cnt, exp_done);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor against the model queues.
    initial begin : monitor
        int      high_cnt;
        int      low_cnt;
        bit      in_strobe;
        bit      have_fall;
        bit      prev_done;
        bit      exp_e;
        strobe_t e;
        logic [3:0]  cap_cmd;
        logic [63:0] cap_data;
        high_cnt = 0; low_cnt = 0; in_strobe = 0; have_fall = 0; prev_done = 0;
        cap_cmd = '0; cap_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_strobe = 0; have_fall = 0; prev_done = 0; high_cnt = 0; low_cnt = 0;
            end else begin
                if (dds_ready) begin
                    if (!in_strobe) begin
                        in_strobe = 1;
                        high_cnt = 0;
                        if (have_fall) chk("strobe_gap", low_cnt >= 4, low_cnt, 4);
                        log_cmd.push_back(dds_cmd);
                        log_data.push_back(dds_data);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_strobe", 1'b0, dds_cmd, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("strobe_cmd", dds_cmd == e.cmd, dds_cmd, e.cmd);
                            chk("strobe_data", dds_data == e.data, dds_data, e.data);
                        end
                        chk("busy_in_strobe", busy == 1'b1, busy, 1);
                        cap_cmd = dds_cmd;
                        cap_data = dds_data;
                    end else begin
                        chk("data_stable", dds_data == cap_data && dds_cmd == cap_cmd, dds_data, cap_data);
                    end
                    high_cnt++;
                end else begin
                    if (in_strobe) begin
                        chk("strobe_width", high_cnt == STROBE, high_cnt, STROBE);
                        in_strobe = 0;
                        have_fall = 1;
                        low_cnt = 0;
                        fall_cyc = cyc;
                    end
                    low_cnt++;
                end
                if (seq_done) begin
                    done_cnt++;
                    chk("busy_at_done", busy == 1'b1, busy, 1);
                    chk("all_strobes_at_done", exp_q.size() == 0, exp_q.size(), 0);
                    if (exp_err_q.size() == 0) begin
                        chk("unexpected_done", 1'b0, 1, 0);
                    end else begin
                        exp_e = exp_err_q.pop_front();
                        chk("error_at_done", error == exp_e, error, exp_e);
                    end
                end
                if (prev_done) chk("busy_after_done", busy == 1'b0, busy, 0);
                prev_done = seq_done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [3:0]  lit_cmd[5];
        logic [63:0] lit_data[5];
        lit_cmd  = '{4'h5, 4'h3, 4'h4, 4'h6, 4'hA};
        lit_data = '{64'h0000F000_00001000, 64'h00000002_00000001, 64'h00000000_00200010,
                     64'h16, 64'h1};

        rst_n = 1'b0; start = 1'b0; dir_only = 1'b0;
        lower_limit = 32'h0000_1000; upper_limit = 32'h0000_F000;
        step_up = 32'd1; step_down = 32'd2;
        rate_up = 16'h0010; rate_down = 16'h0020;
        cfr2_bits = 5'b10110; direction = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", dds_ready == 1'b0, dds_ready, 0);
        chk("rst_busy", busy == 1'b0, busy, 0);
        chk("rst_done", seq_done == 1'b0, seq_done, 0);
        chk("rst_error", error == 1'b0, error, 0);
        chk("rst_cmd", dds_cmd == 4'h0, dds_cmd, 0);
        chk("rst_data", dds_data == 64'h0, dds_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full sequence with a responsive serializer
        log_cmd.delete(); log_data.delete();
        expect_seq(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        chk("lat_load", dds_ready == 1'b0, dds_ready, 0);
        chk("busy_on_accept", busy == 1'b1, busy, 1);
        @(posedge clk); #1;
        chk("lat_strobe", dds_ready == 1'b1, dds_ready, 1);
        wait_seq(2000);
        chk("full_count", log_cmd.size() == 5, log_cmd.size(), 5);
        for (int i = 0; i < 5 && i < log_cmd.size(); i++) begin
            chk("lit_cmd", log_cmd[i] == lit_cmd[i], log_cmd[i], lit_cmd[i]);
            chk("lit_data", log_data[i] == lit_data[i], log_data[i], lit_data[i]);
        end
        chk("full_error", error == 1'b0, error, 0);

        // Direction-only
        log_cmd.delete(); log_data.delete();
        direction = 1'b0;
        expect_seq(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        chk("dir_busy", busy == 1'b1, busy, 1);
        wait_seq(1000);
        chk("dir_count", log_cmd.size() == 1, log_cmd.size(), 1);
        if (log_cmd.size() >= 1) begin
            chk("dir_lit_cmd", log_cmd[0] == 4'hA, log_cmd[0], 4'hA);
            chk("dir_lit_data", log_data[0] == 64'h0, log_data[0], 0);
        end

        // Requests while busy are ignored
        lower_limit = 32'hDEAD_0001; upper_limit = 32'hBEEF_0002;
        step_up = 32'h11; step_down = 32'h22; rate_up = 16'h3; rate_down = 16'h4;
        cfr2_bits = 5'b01001; direction = 1'b1;
        expect_seq(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        repeat (20) @(posedge clk);
        lower_limit = 32'h0; upper_limit = 32'h0;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_seq(2000);

        // Simultaneous start and dir_only: full sequence
        log_cmd.delete(); log_data.delete();
        lower_limit = 32'h0000_0100; upper_limit = 32'h0100_0000;
        step_up = 32'h5; step_down = 32'h6; rate_up = 16'hAAAA; rate_down = 16'h5555;
        cfr2_bits = 5'b11111; direction = 1'b0;
        expect_seq(1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        wait_seq(2000);
        chk("pair_count", log_cmd.size() == 5, log_cmd.size(), 5);

        // Silent serializer: timeout abort after the first command
        ser_respond = 1'b0;
        log_cmd.delete(); log_data.delete();
        expect_seq(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        n = 0;
        while (!error && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_error", error == 1'b1, error, 1);
        chk("timeout_latency", (cyc - fall_cyc) >= 64 && (cyc - fall_cyc) <= 67, cyc - fall_cyc, 65);
        wait_seq(500);
        chk("timeout_count", log_cmd.size() == 1, log_cmd.size(), 1);
        chk("error_sticky", error == 1'b1, error, 1);

        // Next accepted request clears error
        ser_respond = 1'b1;
        expect_seq(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        chk("error_cleared", error == 1'b0, error, 0);
        wait_seq(2000);

        // Reset during the third strobe
        log_cmd.delete(); log_data.delete();
        expect_seq(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        n = 0;
        while (log_cmd.size() < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("reached_step3", log_cmd.size() == 3 && dds_ready == 1'b1, log_cmd.size(), 3);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", dds_ready == 1'b0, dds_ready, 0);
        chk("arst_busy", busy == 1'b0, busy, 0);
        chk("arst_error", error == 1'b0, error, 0);
        chk("arst_data", dds_data == 64'h0, dds_data, 0);
        exp_q.delete();
        exp_err_q.delete();
        exp_done--;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_idle", busy == 1'b0, busy, 0);
        expect_seq(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        chk("post_rst_accept", busy == 1'b1, busy, 1);
        wait_seq(1000);

        chk("total_done", done_cnt == exp_done, done_cnt, exp_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
